// File: rtl/key_debounce_pkg.sv
// Shared types, default timing constants and the counter-width helper
// used by the key debouncer.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } db_state_e;

  localparam int DEF_N_KEYS          = 5;
  localparam int DEF_DEBOUNCE_MS     = 20;
  localparam int DEF_REPEAT_DELAY_MS = 500;
  localparam int DEF_REPEAT_RATE_MS  = 100;

  // One spare bit above the largest count, so increments never wrap.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: two-flop synchronizer, tick-driven state machine,
// debounce and auto-repeat counters, and registered event pulses.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
  parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
  parameter int REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk_in,
  input  logic rst,
  input  logic tick_1khz,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_rpt
);

  localparam int CW = cnt_width(DEBOUNCE_MS, REPEAT_DELAY_MS, REPEAT_RATE_MS);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_MS - 1);
  localparam logic [CW-1:0] RPT_AT     = CW'(REPEAT_DELAY_MS);
  localparam logic [CW-1:0] RPT_RELOAD = (REPEAT_RATE_MS < REPEAT_DELAY_MS)
                                         ? CW'(REPEAT_DELAY_MS - REPEAT_RATE_MS)
                                         : '0;
  localparam logic IDLE_RAW = ACTIVE_LOW;

  logic [1:0]    sync_q;
  logic          key_s;
  db_state_e     state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rcnt;
  logic [CW-1:0] rcnt_nxt;

  // Reset to the idle pin level so leaving reset never looks like an edge.
  always_ff @(posedge clk_in) begin
    if (rst) sync_q <= {2{IDLE_RAW}};
    else     sync_q <= {sync_q[0], key_raw};
  end

  assign key_s    = sync_q[1] ^ ACTIVE_LOW;
  assign rcnt_nxt = rcnt + CW'(1);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rcnt        <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_rpt     <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle; a branch below raises one for
      // exactly the cycle after the accepting tick.
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_rpt     <= 1'b0;
      if (tick_1khz) begin
        case (state)
          IDLE: begin
            if (key_s) begin
              state <= DB_PRESS;
              cnt   <= CW'(1);
            end
          end
          DB_PRESS: begin
            if (!key_s) begin
              state <= IDLE;
            end else if (cnt == DB_LAST) begin
              state     <= HELD;
              key_level <= 1'b1;
              key_press <= 1'b1;
              rcnt      <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          HELD: begin
            if (!key_s) begin
              state <= DB_RELEASE;
              cnt   <= CW'(1);
            end else if (REPEAT_DELAY_MS > 0) begin
              if (rcnt_nxt == RPT_AT) begin
                key_rpt <= 1'b1;
                rcnt    <= RPT_RELOAD;
              end else begin
                rcnt <= rcnt_nxt;
              end
            end
          end
          DB_RELEASE: begin
            // A bounce back to pressed resumes HELD with rcnt untouched.
            if (key_s) begin
              state <= HELD;
            end else if (cnt == DB_LAST) begin
              state       <= IDLE;
              key_level   <= 1'b0;
              key_release <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/key_debounce.sv
// N-key debouncer with press/release/auto-repeat pulses, timed in 1 ms ticks,
// plus a registered any-event flag for the game logic.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS          = DEF_N_KEYS,
  parameter int DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
  parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
  parameter int REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              tick_1khz,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_rpt,
  output logic              any_evt
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_MS    (DEBOUNCE_MS),
      .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
      .REPEAT_RATE_MS (REPEAT_RATE_MS),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk_in     (clk_in),
      .rst        (rst),
      .tick_1khz  (tick_1khz),
      .key_raw    (key_raw[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_rpt    (key_rpt[i])
    );
  end

  always_ff @(posedge clk_in) begin
    if (rst) any_evt <= 1'b0;
    else     any_evt <= |(key_press | key_rpt);
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus queues expected events with their
// tick number, a monitor pops and compares whenever a pulse appears.
module tb_key_debounce;

  localparam int NK = 5;

  typedef struct {
    int           tick;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] rpt;
    logic [NK-1:0] level;
  } exp_t;

  logic          clk_in = 1'b0;
  logic          rst;
  logic          tick_1khz = 1'b0;
  logic [NK-1:0] key_raw, key_raw_al;
  logic [NK-1:0] key_level, key_press, key_release, key_rpt;
  logic [NK-1:0] level_al, press_al, rel_al, rpt_al;
  logic          any_evt, any_evt_al;

  int   tick_no = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   al_pulses = 0;
  logic mon_en = 1'b0;
  logic any_prev = 1'b0;
  exp_t q[$];

  key_debounce #(
    .N_KEYS(NK), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(10), .REPEAT_RATE_MS(3), .ACTIVE_LOW(1'b0)
  ) u_dut (
    .clk_in(clk_in), .rst(rst), .tick_1khz(tick_1khz), .key_raw(key_raw),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_rpt(key_rpt), .any_evt(any_evt)
  );

  key_debounce #(
    .N_KEYS(NK), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(10), .REPEAT_RATE_MS(3), .ACTIVE_LOW(1'b1)
  ) u_dut_al (
    .clk_in(clk_in), .rst(rst), .tick_1khz(tick_1khz), .key_raw(key_raw_al),
    .key_level(level_al), .key_press(press_al), .key_release(rel_al),
    .key_rpt(rpt_al), .any_evt(any_evt_al)
  );

  always #5 clk_in = ~clk_in;

  // One tick every 5 clk_in cycles, changed on the falling edge.
  initial begin
    forever begin
      repeat (4) @(negedge clk_in);
      tick_1khz = 1'b1;
      @(negedge clk_in);
      tick_1khz = 1'b0;
    end
  end

  always @(posedge clk_in) if (tick_1khz) tick_no <= tick_no + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d)", name, act, exp, tick_no);
    else n_pass++;
  endtask

  function automatic void push(input int tk, input logic [NK-1:0] p, input logic [NK-1:0] r,
                               input logic [NK-1:0] rp, input logic [NK-1:0] lv);
    exp_t e;
    e.tick = tk; e.press = p; e.rel = r; e.rpt = rp; e.level = lv;
    q.push_back(e);
  endfunction

  task automatic next_tick();
    do @(posedge clk_in); while (tick_1khz !== 1'b1);
    @(negedge clk_in);
  endtask

  task automatic next_ticks(input int n);
    for (int i = 0; i < n; i++) next_tick();
  endtask

  // Scoreboard monitor for the active-high instance.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (|{key_press, key_release, key_rpt}) begin
        if (q.size() == 0) begin
          check("unexpected_evt", {17'd0, key_press, key_release, key_rpt}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("evt_tick", tick_no, e.tick);
          check("evt_press", key_press, e.press);
          check("evt_release", key_release, e.rel);
          check("evt_rpt", key_rpt, e.rpt);
          check("evt_level", key_level, e.level);
        end
      end
      if (any_prev || any_evt) check("any_evt", any_evt, any_prev);
      any_prev = |(key_press | key_rpt);
      if (|{press_al, rel_al, rpt_al}) al_pulses++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    key_raw    = '0;
    key_raw_al = '1;
    rst        = 1'b1;
    repeat (3) @(negedge clk_in);
    check("rst_level", key_level, 0);
    check("rst_press", key_press, 0);
    check("rst_release", key_release, 0);
    check("rst_rpt", key_rpt, 0);
    check("rst_any_evt", any_evt, 0);
    check("rst_al_level", level_al, 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Clean press then release on key 0.
    next_tick(); t = tick_no;
    key_raw[0] = 1'b1;
    push(t + 4, 5'b00001, 5'b00000, 5'b00000, 5'b00001);
    next_ticks(5);
    check("clean_level_held", key_level, 5'b00001);
    key_raw[0] = 1'b0;
    push(t + 9, 5'b00000, 5'b00001, 5'b00000, 5'b00000);
    next_ticks(5);
    check("clean_level_released", key_level, 5'b00000);

    // Bounce on key 1: three ticks high is not enough; a fresh press needs four.
    key_raw[1] = 1'b1;
    next_ticks(3);
    key_raw[1] = 1'b0;
    next_ticks(3);
    check("bounce_level", key_level, 5'b00000);
    t = tick_no;
    key_raw[1] = 1'b1;
    push(t + 4, 5'b00010, 5'b00000, 5'b00000, 5'b00010);
    next_ticks(3);
    check("bounce_not_early", key_level, 5'b00000);
    next_tick();
    check("bounce_fresh_level", key_level, 5'b00010);
    key_raw[1] = 1'b0;
    push(t + 8, 5'b00000, 5'b00010, 5'b00000, 5'b00000);
    next_ticks(5);

    // Auto-repeat on key 2: press at +4, repeats at +14, +17, +20.
    t = tick_no;
    key_raw[2] = 1'b1;
    push(t + 4,  5'b00100, 5'b00000, 5'b00000, 5'b00100);
    push(t + 14, 5'b00000, 5'b00000, 5'b00100, 5'b00100);
    push(t + 17, 5'b00000, 5'b00000, 5'b00100, 5'b00100);
    push(t + 20, 5'b00000, 5'b00000, 5'b00100, 5'b00100);
    next_ticks(20);
    key_raw[2] = 1'b0;
    push(t + 24, 5'b00000, 5'b00100, 5'b00000, 5'b00000);
    next_ticks(5);

    // Release glitch on key 4: two low ticks are ignored, four release it.
    t = tick_no;
    key_raw[4] = 1'b1;
    push(t + 4, 5'b10000, 5'b00000, 5'b00000, 5'b10000);
    next_ticks(6);
    key_raw[4] = 1'b0;
    next_ticks(2);
    key_raw[4] = 1'b1;
    next_ticks(2);
    check("glitch_level", key_level, 5'b10000);
    key_raw[4] = 1'b0;
    push(t + 14, 5'b00000, 5'b10000, 5'b00000, 5'b00000);
    next_ticks(5);

    // Keys 0 and 3 together, then reset while both are held.
    t = tick_no;
    key_raw = 5'b01001;
    push(t + 4, 5'b01001, 5'b00000, 5'b00000, 5'b01001);
    next_ticks(5);
    check("simul_level", key_level, 5'b01001);
    rst = 1'b1;
    @(negedge clk_in);
    check("midrst_level", key_level, 0);
    check("midrst_release", key_release, 0);
    check("midrst_press", key_press, 0);
    check("midrst_any_evt", any_evt, 0);
    key_raw = '0;
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    next_ticks(6);
    check("post_rst_level", key_level, 0);

    // Active-low instance: idle-high pins never pressed, then press key 2.
    check("al_idle_level", level_al, 0);
    check("al_idle_pulses", al_pulses, 0);
    key_raw_al[2] = 1'b0;
    next_ticks(4);
    check("al_press", press_al, 5'b00100);
    check("al_level", level_al, 5'b00100);
    next_ticks(2);
    check("al_pulse_count", al_pulses, 1);
    check("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Downstream consumer of the 1 kHz divider strobe. The strobe is one clk_in cycle high every 100000 cycles at 100 MHz.
- Debounces N push-buttons for the VGA game logic.
- Outputs per key: a clean level, a one-cycle press pulse, a one-cycle release pulse, and auto-repeat pulses while a key is held.
- All timing is counted in 1 ms ticks, not in clk_in cycles.

Parameters:
- N_KEYS, 5, number of independent buttons.
- DEBOUNCE_MS, 20, consecutive equal ticks needed to accept a level change. Must be >= 2.
- REPEAT_DELAY_MS, 500, held ticks from acceptance to the first repeat. 0 disables auto-repeat.
- REPEAT_RATE_MS, 100, ticks between later repeats. Must be >= 1.
- ACTIVE_LOW, 0, 1 = raw pressed level is 0.

Ports:
- clk_in  in  1  system clock, 100 MHz.
- rst  in  1  reset, synchronous, active-high.
- tick_1khz  in  1  one-cycle strobe from the 1 kHz divider.
- key_raw  in  N_KEYS  asynchronous button pins.
- key_level  out  N_KEYS  debounced pressed state.
- key_press  out  N_KEYS  one-cycle pulse on accepted press.
- key_release  out  N_KEYS  one-cycle pulse on accepted release.
- key_rpt  out  N_KEYS  one-cycle auto-repeat pulse.
- any_evt  out  1  registered OR of all press and repeat pulses.

Behaviour:
- Synchronizer:
  - Each key_raw bit passes through 2 flops on clk_in, then is inverted if ACTIVE_LOW, giving key_s.
  - Synchronizer flops reset to the inactive raw level: 0, or 1 when ACTIVE_LOW.
- FSM, one per key. State and counters change only in cycles where tick_1khz=1. tick high for k consecutive cycles counts as k ticks.
- IDLE:
  - key_s=1 → go to DB_PRESS, cnt=1.
- DB_PRESS:
  - key_s=0 → go to IDLE.
  - cnt==DEBOUNCE_MS-1 → go to HELD; key_level=1; pulse key_press; rcnt=0.
  - Otherwise cnt++.
- HELD:
  - key_s=0 → go to DB_RELEASE, cnt=1.
  - Otherwise rcnt++.
  - When REPEAT_DELAY_MS>0, pulse key_rpt when rcnt reaches REPEAT_DELAY_MS. Then rcnt reloads to REPEAT_DELAY_MS-REPEAT_RATE_MS, so repeats fire every REPEAT_RATE_MS ticks.
- DB_RELEASE:
  - key_s=1 → go back to HELD. rcnt is frozen, no pulse.
  - cnt==DEBOUNCE_MS-1 → go to IDLE; key_level=0; pulse key_release.
  - Otherwise cnt++.
- Output pulses:
  - All pulses are registered, high exactly one clk_in cycle: the cycle after the accepting tick edge.
  - key_level changes on that same edge.
  - any_evt lags key_press/key_rpt by one further cycle.
- Latency: a clean press is accepted on the DEBOUNCE_MS-th consecutive tick that samples 1. Sampling sees key_raw 2 clk_in cycles late.
- Counter widths: $clog2 of the max of DEBOUNCE_MS, REPEAT_DELAY_MS and REPEAT_RATE_MS, plus 1. No wrap-around is possible by construction.
- Boundaries:
  - A single tick sampling the opposite level restarts debounce from zero.
  - Keys are fully independent; simultaneous events on several keys all pulse in the same cycle.
  - Press and release never pulse in the same cycle for one key.
  - key_rpt is never coincident with key_press.
- Reset, including mid-operation: on the next edge all FSMs go to IDLE, counters to 0, all outputs to 0. No release pulse is generated.

Decomposition:
- Shared package:
  - FSM state enum: IDLE, DB_PRESS, HELD, DB_RELEASE.
  - Counter-width function.
  - Default timing constants.
- Sub-module key_debounce_ch holds one synchronizer, one FSM and the counters. The top generates N_KEYS copies and the any_evt register.

Test Plan:
Bench configuration: DEBOUNCE_MS=4, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=3, tick every 5 clk_in cycles.
- Clean press: key_raw[0]=1 and held → key_press[0] high one cycle after the 4th sampling tick; key_level[0]=1 from then on; no other outputs.
- Bounce: key_raw[1]=1 for 3 ticks, then 0 → no key_press, key_level[1] stays 0. A fresh press after that still needs 4 ticks.
- Auto-repeat: hold key 2 for 20 ticks → press at tick 4; key_rpt at ticks 14, 17, 20; any_evt follows each pulse by one cycle.
- Release glitch: held key drops to 0 for 2 ticks, then returns to 1 → no release, no press. Then 0 for 4 ticks → key_release one cycle after the 4th; key_level=0.
- Reset in HELD, and ACTIVE_LOW=1 with key_raw idle high:
  - rst asserted → all outputs 0 on the next cycle, no key_release.
  - After reset, with key_raw held at 1 → no press ever.
- Simultaneous keys: keys 0 and 3 pressed on the same tick → both key_press bits high in the same cycle; any_evt high once, for one cycle.
